// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath: default geometry,
// the partial-sum type and the FIFO pointer width helper.
package systolic_pkg;

    localparam int PSUM_BW = 32;
    localparam int COL     = 2;
    localparam int DEPTH   = 64;

    typedef logic signed [PSUM_BW-1:0] psum_t;

    // Pointer width for a FIFO of the given depth: address bits plus one wrap bit
    // so that full and empty can be told apart when the address bits match.
    function automatic int ptrW(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/psum_ofifo_col.sv
// Single-column show-ahead FIFO: memory, read/write pointers, status and
// a one-cycle pulse when a write is dropped because the column is full.
module ofifo_col
    import systolic_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [psum_bw-1:0] din,
    input  logic               pop,
    output logic [psum_bw-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic               ovf
);

    localparam int PW = ptrW(depth);
    localparam int AW = PW - 1;

    logic [psum_bw-1:0] mem_q [depth];
    logic [PW-1:0]      wPtr_q, wPtr_d;
    logic [PW-1:0]      rPtr_q, rPtr_d;
    logic               accept;

    assign empty = (wPtr_q == rPtr_q);
    assign full  = (wPtr_q[AW-1:0] == rPtr_q[AW-1:0]) && (wPtr_q[AW] != rPtr_q[AW]);
    assign dout  = mem_q[rPtr_q[AW-1:0]];

    // A full column may still take a write in the cycle its head is popped,
    // because the pop frees the slot the write lands in.
    always_comb begin
        accept = wr && (!full || pop);
        ovf    = wr && full && !pop;
        wPtr_d = wPtr_q + PW'(accept);
        rPtr_d = rPtr_q + PW'(pop);
    end

    // Pointer registers; the wrap bit rolls over naturally modulo 2*depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wPtr_q <= '0;
            rPtr_q <= '0;
        end else begin
            wPtr_q <= wPtr_d;
            rPtr_q <= rPtr_d;
        end
    end

    // Storage needs no reset: an entry is only visible once the write pointer passes it.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wPtr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/psum_ofifo.sv
// Output FIFO behind the MAC array: one FIFO per column absorbs the column
// skew, and a row is offered downstream only once every column has data.
module psum_ofifo
    import systolic_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_ovf,
    output logic                   o_udf
);

    logic [psum_bw*col-1:0] rowData;
    logic [col-1:0]         colEmpty;
    logic [col-1:0]         colFull;
    logic [col-1:0]         colOvf;
    logic                   rowValid;
    logic                   pop;
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;

    for (genvar c = 0; c < col; c++) begin : gCol
        ofifo_col #(
            .psum_bw(psum_bw),
            .depth  (depth)
        ) uCol (
            .clk  (clk),
            .reset(reset),
            .wr   (wr[c]),
            .din  (in[psum_bw*c +: psum_bw]),
            .pop  (pop),
            .dout (rowData[psum_bw*c +: psum_bw]),
            .empty(colEmpty[c]),
            .full (colFull[c]),
            .ovf  (colOvf[c])
        );
    end

    // Row alignment: a row exists only when no column is empty, and a pop
    // moves every column together so the columns stay in lockstep.
    always_comb begin
        rowValid = &(~colEmpty);
        pop      = rd && rowValid;
        ovf_d    = ovf_q | (|colOvf);
        udf_d    = udf_q | (rd && !rowValid);
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign out     = rowValid ? rowData : '0;
    assign o_valid = rowValid;
    assign o_full  = |colFull;
    assign o_ready = ~o_full;
    assign o_ovf   = ovf_q;
    assign o_udf   = udf_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo (2 columns, 32-bit psums, depth 4) against a
// queue-based model of the per-column FIFOs and sticky flags.
module tb_psum_ofifo;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [63:0] inBus;
    logic [1:0]  wr;
    logic        rd;
    logic [63:0] outBus;
    logic        oValid, oFull, oReady, oOvf, oUdf;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        mOvf, mUdf;
    int          total, bad;

    psum_ofifo #(.col(2), .psum_bw(32), .depth(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (inBus),
        .wr     (wr),
        .rd     (rd),
        .out    (outBus),
        .o_valid(oValid),
        .o_full (oFull),
        .o_ready(oReady),
        .o_ovf  (oOvf),
        .o_udf  (oUdf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic expValid();
        return (q0.size() > 0) && (q1.size() > 0);
    endfunction

    function automatic logic [63:0] expOut();
        if (q0.size() > 0 && q1.size() > 0) return {q1[0], q0[0]};
        return 64'd0;
    endfunction

    function automatic logic expFull();
        return (q0.size() == DEPTH) || (q1.size() == DEPTH);
    endfunction

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input logic [1:0] w, input logic [31:0] d0, input logic [31:0] d1, input logic r);
        logic mPop, acc0, acc1;
        wr    = w;
        inBus = {d1, d0};
        rd    = r;
        mPop  = r && expValid();
        if (r && !mPop) mUdf = 1'b1;
        acc0 = w[0] && (q0.size() < DEPTH || mPop);
        acc1 = w[1] && (q1.size() < DEPTH || mPop);
        if (w[0] && !acc0) mOvf = 1'b1;
        if (w[1] && !acc1) mOvf = 1'b1;
        if (mPop) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        if (acc0) q0.push_back(d0);
        if (acc1) q1.push_back(d1);
        @(posedge clk);
        #1;
        wr = 2'b00;
        rd = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        wr    = 2'b00;
        rd    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q0.delete();
        q1.delete();
        mOvf = 1'b0;
        mUdf = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        total++; if (oValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", oValid); end
        total++; if (oFull !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b want=0", oFull); end
        total++; if (oReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", oReady); end
        total++; if (outBus !== 64'd0) begin bad++; $display("[TB] FAIL reset_out got=%h want=0", outBus); end
        total++; if (oOvf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0", oOvf); end
        total++; if (oUdf !== 1'b0) begin bad++; $display("[TB] FAIL reset_udf got=%b want=0", oUdf); end
    endtask

    task automatic test_skewed();
        logic [31:0] pos, neg;
        pos = 32'd180;
        neg = -32'sd180;
        cycle(2'b01, pos, 32'd0, 1'b0);
        total++; if (oValid !== 1'b0) begin bad++; $display("[TB] FAIL skew_valid1 got=%b want=0", oValid); end
        cycle(2'b10, 32'd0, neg, 1'b0);
        total++; if (oValid !== 1'b1) begin bad++; $display("[TB] FAIL skew_valid2 got=%b want=1", oValid); end
        total++; if (outBus !== {neg, pos}) begin bad++; $display("[TB] FAIL skew_out got=%h want=%h", outBus, {neg, pos}); end
        cycle(2'b00, 32'd0, 32'd0, 1'b1);
        total++; if (oValid !== 1'b0) begin bad++; $display("[TB] FAIL skew_pop_valid got=%b want=0", oValid); end
        total++; if (outBus !== 64'd0) begin bad++; $display("[TB] FAIL skew_pop_out got=%h want=0", outBus); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) cycle(2'b01, 32'(i), 32'd0, 1'b0);
        total++; if (oFull !== 1'b1) begin bad++; $display("[TB] FAIL fill_full got=%b want=1", oFull); end
        total++; if (oReady !== 1'b0) begin bad++; $display("[TB] FAIL fill_ready got=%b want=0", oReady); end
        cycle(2'b01, 32'd5, 32'd0, 1'b0);
        total++; if (oOvf !== 1'b1) begin bad++; $display("[TB] FAIL fill_ovf got=%b want=1", oOvf); end
        for (int i = 0; i < 4; i++) cycle(2'b10, 32'd0, 32'(100 + i), 1'b0);
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (outBus !== {32'(99 + i), 32'(i)}) begin
                bad++;
                $display("[TB] FAIL fill_order%0d got=%h want=%h", i, outBus, {32'(99 + i), 32'(i)});
            end
            cycle(2'b00, 32'd0, 32'd0, 1'b1);
        end
        total++; if (oValid !== 1'b0) begin bad++; $display("[TB] FAIL fill_drained got=%b want=0", oValid); end
    endtask

    task automatic test_wrap();
        doReset();
        for (int i = 0; i < 4; i++) cycle(2'b01, 32'(10 + i), 32'd0, 1'b0);
        cycle(2'b10, 32'd0, 32'd50, 1'b0);
        cycle(2'b01, 32'd9, 32'd0, 1'b1);
        total++; if (oFull !== 1'b1) begin bad++; $display("[TB] FAIL wrap_full got=%b want=1", oFull); end
        total++; if (oOvf !== 1'b0) begin bad++; $display("[TB] FAIL wrap_ovf got=%b want=0", oOvf); end
        cycle(2'b10, 32'd0, 32'd51, 1'b0);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (outBus !== expOut() || oFull !== 1'b1 || oOvf !== 1'b0) begin
                bad++;
                $display("[TB] FAIL wrap_iter%0d got=%h/%b/%b want=%h/1/0", i, outBus, oFull, oOvf, expOut());
            end
            cycle(2'b11, 32'(200 + i), 32'(300 + i), 1'b1);
        end
        total++; if (outBus !== expOut()) begin bad++; $display("[TB] FAIL wrap_final got=%h want=%h", outBus, expOut()); end
    endtask

    task automatic test_udf();
        doReset();
        cycle(2'b10, 32'd0, 32'd77, 1'b0);
        cycle(2'b00, 32'd0, 32'd0, 1'b1);
        total++; if (oUdf !== 1'b1) begin bad++; $display("[TB] FAIL udf_flag got=%b want=1", oUdf); end
        total++; if (oValid !== 1'b0) begin bad++; $display("[TB] FAIL udf_valid got=%b want=0", oValid); end
        cycle(2'b01, 32'd5, 32'd0, 1'b0);
        total++; if (outBus !== {32'd77, 32'd5}) begin bad++; $display("[TB] FAIL udf_intact got=%h want=%h", outBus, {32'd77, 32'd5}); end
    endtask

    task automatic test_reset_mid();
        doReset();
        cycle(2'b00, 32'd0, 32'd0, 1'b1);
        cycle(2'b11, 32'd1, 32'd2, 1'b0);
        cycle(2'b11, 32'd3, 32'd4, 1'b0);
        cycle(2'b01, 32'd5, 32'd0, 1'b0);
        doReset();
        total++; if (oValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid got=%b want=0", oValid); end
        total++; if (outBus !== 64'd0) begin bad++; $display("[TB] FAIL mid_out got=%h want=0", outBus); end
        total++; if (oUdf !== 1'b0 || oOvf !== 1'b0) begin bad++; $display("[TB] FAIL mid_flags got=%b%b want=00", oUdf, oOvf); end
        test_skewed();
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 400; i++) begin
            cycle(2'($urandom_range(0, 3)), $urandom, $urandom, ($urandom_range(0, 9) < 4));
            total++;
            if (oValid !== expValid() || outBus !== expOut() || oFull !== expFull() ||
                oReady !== !expFull() || oOvf !== mOvf || oUdf !== mUdf) begin
                bad++;
                $display("[TB] FAIL rand%0d got=%b %h %b %b %b %b want=%b %h %b %b %b %b", i,
                         oValid, outBus, oFull, oReady, oOvf, oUdf,
                         expValid(), expOut(), expFull(), !expFull(), mOvf, mUdf);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        wr    = 2'b00;
        rd    = 1'b0;
        inBus = 64'd0;
        mOvf  = 1'b0;
        mUdf  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_skewed();
        test_fill();
        test_wrap();
        test_udf();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
